// File: rtl/gen_pkg.sv
// gen_pkg: state encoding, default widths and the saturating-count helper
// shared by the generator fold stage.
`default_nettype none

package gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        COLLECT = 2'd2,
        RESULT  = 2'd3
    } reduce_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;
    localparam int SUM_W_DEF = 48;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Widths up to 64 bits are handled by widening; callers narrow the result.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] limit);
        return (value >= limit) ? value : value + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gen_reduce_alu.sv
// gen_reduce_alu: combinational next-state for sum, count, min, max and the
// sticky overflow flag; values pass through unchanged when no sample is accepted.
`default_nettype none

module gen_reduce_alu
    import gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic                    accept,
    input  logic signed [WIDTH-1:0] sample,
    input  logic signed [SUM_W-1:0] sum,
    input  logic        [CNT_W-1:0] count,
    input  logic signed [WIDTH-1:0] vmin,
    input  logic signed [WIDTH-1:0] vmax,
    input  logic                    ovf,
    output logic signed [SUM_W-1:0] sum_next,
    output logic        [CNT_W-1:0] count_next,
    output logic signed [WIDTH-1:0] min_next,
    output logic signed [WIDTH-1:0] max_next,
    output logic                    ovf_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic signed [SUM_W-1:0] sample_ext;
    logic signed [SUM_W-1:0] sum_add;
    logic                    sum_wrap;
    logic                    cnt_sat;

    always_comb begin
        sample_ext = SUM_W'(sample);
        sum_add    = sum + sample_ext;
        // Signed overflow: operands agree in sign but the result does not.
        sum_wrap   = (sum[SUM_W-1] == sample_ext[SUM_W-1]) && (sum_add[SUM_W-1] != sum[SUM_W-1]);
        cnt_sat    = (count == CNT_MAX);

        sum_next   = sum;
        count_next = count;
        min_next   = vmin;
        max_next   = vmax;
        ovf_next   = ovf;
        if (accept) begin
            sum_next   = sum_add;
            count_next = CNT_W'(sat_inc(64'(count), 64'(CNT_MAX)));
            min_next   = (sample < vmin) ? sample : vmin;
            max_next   = (sample > vmax) ? sample : vmax;
            ovf_next   = ovf | sum_wrap | cnt_sat;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gen_reduce.sv
// gen_reduce: launches a generator, folds its sample stream into sum/count/min/max
// and returns one result record over valid/ready. Option macro: STALL_INJECT_EN.
`default_nettype none

module gen_reduce
    import gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [SUM_W-1:0] _out0,
    output logic        [CNT_W-1:0] _out1,
    output logic signed [WIDTH-1:0] _out2,
    output logic signed [WIDTH-1:0] _out3,
    output logic                    _out4,
    output logic                    gen_start,
    output logic                    gen_ready,
    input  logic                    gen_valid,
    input  logic                    gen_done,
    input  logic signed [WIDTH-1:0] gen_out0
);

    localparam logic signed [WIDTH-1:0] MIN_INIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MAX_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    reduce_state_t           state;
    logic signed [SUM_W-1:0] sum, sum_next;
    logic        [CNT_W-1:0] count, count_next;
    logic signed [WIDTH-1:0] vmin, vmax, min_next, max_next;
    logic                    ovf, ovf_next;
    logic                    accept, finish, ready_gate;

    assign accept = (state == COLLECT) && gen_valid && gen_ready;
    assign finish = (state == COLLECT) && gen_done && gen_ready;

`ifdef STALL_INJECT_EN
    logic [7:0] lfsr, lfsr_next;

    assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // gen_ready is registered, so gate on the value lfsr takes next cycle.
    assign ready_gate = (lfsr_next[1:0] != 2'b00);

    always_ff @(posedge _clock) begin
        if (_reset) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_next;
    end
`else
    assign ready_gate = 1'b1;
`endif

    gen_reduce_alu #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_alu (
        .accept     (accept),
        .sample     (gen_out0),
        .sum        (sum),
        .count      (count),
        .vmin       (vmin),
        .vmax       (vmax),
        .ovf        (ovf),
        .sum_next   (sum_next),
        .count_next (count_next),
        .min_next   (min_next),
        .max_next   (max_next),
        .ovf_next   (ovf_next)
    );

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state     <= IDLE;
            _valid    <= 1'b0;
            _done     <= 1'b1;
            gen_start <= 1'b0;
            gen_ready <= 1'b0;
            _out0     <= '0;
            _out1     <= '0;
            _out2     <= '0;
            _out3     <= '0;
            _out4     <= 1'b0;
            sum       <= '0;
            count     <= '0;
            vmin      <= MIN_INIT;
            vmax      <= MAX_INIT;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (_start) begin
                        sum       <= '0;
                        count     <= '0;
                        vmin      <= MIN_INIT;
                        vmax      <= MAX_INIT;
                        ovf       <= 1'b0;
                        _done     <= 1'b0;
                        gen_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    gen_start <= 1'b0;
                    gen_ready <= ready_gate;
                    state     <= COLLECT;
                end
                COLLECT: begin
                    sum   <= sum_next;
                    count <= count_next;
                    vmin  <= min_next;
                    vmax  <= max_next;
                    ovf   <= ovf_next;
                    if (finish) begin
                        // The terminating cycle's sample is already folded into *_next.
                        gen_ready <= 1'b0;
                        _valid    <= 1'b1;
                        _out0     <= sum_next;
                        _out1     <= count_next;
                        _out2     <= (count_next == '0) ? '0 : min_next;
                        _out3     <= (count_next == '0) ? '0 : max_next;
                        _out4     <= ovf_next;
                        state     <= RESULT;
                    end else begin
                        gen_ready <= ready_gate;
                    end
                end
                RESULT: begin
                    if (_ready) begin
                        _valid <= 1'b0;
                        _done  <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gen_reduce.sv
// tb_gen_reduce: randomized generator stub plus a list-level reference model
// for gen_reduce; summary line reports vectors and miscompares.
`default_nettype none

module tb_gen_reduce;

    localparam int WIDTH = 16;
    localparam int CNT_W = 6;
    localparam int SUM_W = 20;

    localparam longint SPAN = longint'(1) << SUM_W;
    localparam longint SMAX = SPAN / 2 - 1;
    localparam longint SMIN = -(SPAN / 2);
    localparam longint CMAX = (longint'(1) << CNT_W) - 1;

    typedef struct {
        longint sum;
        longint cnt;
        longint mn;
        longint mx;
        bit     ovf;
    } res_t;

    logic                    _clock = 1'b0;
    logic                    _reset, _start, _ready;
    logic                    _valid, _done;
    logic signed [SUM_W-1:0] _out0;
    logic        [CNT_W-1:0] _out1;
    logic signed [WIDTH-1:0] _out2, _out3;
    logic                    _out4;
    logic                    gen_start, gen_ready;
    logic                    gen_valid = 1'b0, gen_done = 1'b0;
    logic signed [WIDTH-1:0] gen_out0 = '0;

    gen_reduce #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        ._clock    (_clock),
        ._reset    (_reset),
        ._start    (_start),
        ._ready    (_ready),
        ._valid    (_valid),
        ._done     (_done),
        ._out0     (_out0),
        ._out1     (_out1),
        ._out2     (_out2),
        ._out3     (_out3),
        ._out4     (_out4),
        .gen_start (gen_start),
        .gen_ready (gen_ready),
        .gen_valid (gen_valid),
        .gen_done  (gen_done),
        .gen_out0  (gen_out0)
    );

    always #5 _clock = ~_clock;

    int   vectors = 0;
    int   fails = 0;
    res_t exp_q[$];
    int   job_q[$];
    bit   stub_dwl = 0, stub_stall = 0;
    int   stub_pops = 0;
    int   stall_lows = 0;
    int   starts_seen = 0;
    int   jobs_launched = 0;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain running arithmetic over the whole sample list.
    function automatic res_t model(input int s[$]);
        res_t   r;
        longint n;
        r.sum = 0; r.ovf = 0; r.mn = 0; r.mx = 0; r.cnt = 0;
        n = 0;
        foreach (s[i]) begin
            r.sum += s[i];
            if (r.sum > SMAX) begin r.sum -= SPAN; r.ovf = 1; end
            else if (r.sum < SMIN) begin r.sum += SPAN; r.ovf = 1; end
            if (i == 0 || s[i] < r.mn) r.mn = s[i];
            if (i == 0 || s[i] > r.mx) r.mx = s[i];
            n++;
        end
        if (n > CMAX) begin r.cnt = CMAX; r.ovf = 1; end
        else r.cnt = n;
        return r;
    endfunction

    // Compare process: result contents, handshake behaviour, launch pulse shape.
    bit prev_valid = 0, prev_gs = 0;
    always @(posedge _clock) begin
        #1;
        if (_reset) begin
            prev_valid = 0;
            prev_gs    = 0;
        end else begin
            if (prev_valid && _ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                check("post_handshake_valid", _valid, 0);
                check("post_handshake_done", _done, 1);
            end
            if (_valid) begin
                check("pending_jobs", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    check("sum", $signed(_out0), exp_q[0].sum);
                    check("count", _out1, exp_q[0].cnt);
                    check("min", $signed(_out2), exp_q[0].mn);
                    check("max", $signed(_out3), exp_q[0].mx);
                    check("overflow", _out4, exp_q[0].ovf);
                end
                check("busy_done", _done, 0);
            end
            if (gen_start) begin
                check("start_pulse_width", prev_gs, 0);
                check("launch_done", _done, 0);
                check("launch_gen_ready", gen_ready, 0);
                if (!prev_gs) starts_seen++;
            end
            prev_valid = _valid;
            prev_gs    = gen_start;
        end
    end

    // Generator stub: serves job_q, random stalls, noise when not launched.
    bit active = 0, vdrv = 0, ddrv = 0, last_ready = 0;
    int sq[$];
    always @(posedge _clock) begin
        #2;
        if (_reset) begin
            active     = 0;
            sq.delete();
            last_ready = 0;
        end else begin
            if (active && last_ready) begin
                if (vdrv) begin
                    void'(sq.pop_front());
                    stub_pops++;
                end
                if (ddrv) begin
                    active = 0;
                    check("result_latency", _valid, 1);
                end
            end
            if (gen_start && !active) begin
                active = 1;
                sq     = job_q;
            end
            if (active && !gen_start && !gen_ready) stall_lows++;
        end
        if (active) begin
            if (stub_stall && $urandom_range(0, 3) == 0) begin
                vdrv = 0; ddrv = 0;
            end else if (sq.size() == 0) begin
                vdrv = 0; ddrv = 1;
            end else begin
                vdrv = 1; ddrv = stub_dwl && (sq.size() == 1);
            end
            gen_out0 = vdrv ? WIDTH'(sq[0]) : WIDTH'($urandom);
        end else begin
            vdrv     = 1'($urandom_range(0, 1));
            ddrv     = 1'($urandom_range(0, 1));
            gen_out0 = WIDTH'($urandom);
        end
        gen_valid  = vdrv;
        gen_done   = ddrv;
        last_ready = gen_ready;
    end

    task automatic run_job(input int s[$], input bit dwl, input bit stall, input int hold,
                           input bit lit, input res_t want);
        res_t m;
        int   waited;
        m = model(s);
        if (lit) begin
            check("model_sum", m.sum, want.sum);
            check("model_count", m.cnt, want.cnt);
            check("model_min", m.mn, want.mn);
            check("model_max", m.mx, want.mx);
            check("model_ovf", m.ovf, want.ovf);
        end
        job_q      = s;
        stub_dwl   = dwl;
        stub_stall = stall;
        exp_q.push_back(m);
        jobs_launched++;
        @(negedge _clock); _start = 1;
        @(negedge _clock); _start = 0;
        waited = 0;
        while (!_valid && waited < 1000) begin
            @(negedge _clock);
            waited++;
        end
        if (!_valid) begin
            vectors++;
            fails++;
            $display("FAIL job_timeout: no result after %0d cycles, expected one", waited);
            exp_q.delete();
            return;
        end
        if (lit) begin
            check("dut_sum", $signed(_out0), want.sum);
            check("dut_count", _out1, want.cnt);
            check("dut_min", $signed(_out2), want.mn);
            check("dut_max", $signed(_out3), want.mx);
            check("dut_ovf", _out4, want.ovf);
        end
        for (int i = 0; i < hold; i++) begin
            _start = (i == 1);
            @(negedge _clock);
        end
        _start = 0;
        _ready = 1;
        @(negedge _clock);
        _ready = 0;
        check("job_done", _done, 1);
    endtask

    initial begin
        int   q[$];
        int   base, waited;
        res_t none;
        none = '{sum: 0, cnt: 0, mn: 0, mx: 0, ovf: 0};
        _reset = 1; _start = 0; _ready = 0;
        repeat (3) @(negedge _clock);
        check("rst_valid", _valid, 0);
        check("rst_done", _done, 1);
        check("rst_gen_start", gen_start, 0);
        check("rst_gen_ready", gen_ready, 0);
        check("rst_out0", _out0, 0);
        _reset = 0;
        @(negedge _clock);

        q = '{1, 4, 7, 10};
        run_job(q, 0, 0, 0, 1, '{sum: 22, cnt: 4, mn: 1, mx: 10, ovf: 0});
        q = '{0, 2, 4, 6, 8};
        repeat (3) run_job(q, 0, 0, 0, 1, '{sum: 20, cnt: 5, mn: 0, mx: 8, ovf: 0});
        q.delete();
        run_job(q, 0, 0, 0, 1, '{sum: 0, cnt: 0, mn: 0, mx: 0, ovf: 0});
        q = '{-3, 7, -10};
        run_job(q, 1, 0, 0, 1, '{sum: -6, cnt: 3, mn: -10, mx: 7, ovf: 0});
        q = '{1, 4, 7, 10};
        run_job(q, 0, 0, 3, 1, '{sum: 22, cnt: 4, mn: 1, mx: 10, ovf: 0});

        // Abort a job mid-collection.
        base = stub_pops;
        job_q = '{10, 11, 12, 13, 14, 15, 16, 17};
        stub_dwl = 0; stub_stall = 0;
        jobs_launched++;
        @(negedge _clock); _start = 1;
        @(negedge _clock); _start = 0;
        waited = 0;
        while (stub_pops - base < 2 && waited < 100) begin
            @(negedge _clock);
            waited++;
        end
        check("abort_setup_samples", (stub_pops - base) >= 2, 1);
        _reset = 1;
        @(posedge _clock); #1;
        check("abort_done", _done, 1);
        check("abort_valid", _valid, 0);
        check("abort_gen_ready", gen_ready, 0);
        check("abort_gen_start", gen_start, 0);
        check("abort_out0", _out0, 0);
        check("abort_out1", _out1, 0);
        check("abort_out4", _out4, 0);
        @(negedge _clock); _reset = 0;
        @(negedge _clock);
        q = '{0, 2, 4, 6, 8};
        run_job(q, 0, 0, 0, 1, '{sum: 20, cnt: 5, mn: 0, mx: 8, ovf: 0});

        q.delete();
        repeat (20) q.push_back(32767);
        run_job(q, 0, 1, 1, 1, '{sum: -393236, cnt: 20, mn: 32767, mx: 32767, ovf: 1});
        q.delete();
        repeat (20) q.push_back(-32768);
        run_job(q, 1, 1, 0, 1, '{sum: 393216, cnt: 20, mn: -32768, mx: -32768, ovf: 1});
        q.delete();
        repeat (63) q.push_back(1);
        run_job(q, 0, 0, 0, 1, '{sum: 63, cnt: 63, mn: 1, mx: 1, ovf: 0});
        q.push_back(1);
        run_job(q, 0, 0, 0, 1, '{sum: 64, cnt: 63, mn: 1, mx: 1, ovf: 1});

        for (int j = 0; j < 30; j++) begin
            q.delete();
            for (int k = 0; k < int'($urandom_range(0, 12)); k++)
                q.push_back(int'($urandom_range(0, 65535)) - 32768);
            run_job(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 0, none);
        end

        repeat (3) @(negedge _clock);
`ifdef STALL_INJECT_EN
        check("gen_ready_low_seen", stall_lows > 0, 1);
`else
        check("gen_ready_gaps", stall_lows, 0);
`endif
        check("launch_count", starts_seen, jobs_launched);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
